audio_filter_sched: RTL and testbench
=====================================

Name: audio_filter_sched

Overview:
Sequencer between the audio CODEC FIFO interface and a single shared moving-average datapath.
- Per stereo sample it pulls one L/R pair from the CODEC and time-multiplexes one adder/subtractor and one delay-line RAM between the two channels.
- It pushes the filtered pair back to the CODEC.
- Filter length is selected at run time, changes only on sample boundaries, and a change flushes the filter history.
- Instantiated at top level in place of per-length filter copies; the select input is driven from the KEY decode.

Parameters:
MAX_SHIFT, 6, log2 of the maximum window; delay line depth is 2^MAX_SHIFT entries per channel.
WR_TIMEOUT, 2048, clk cycles to wait for write_ready before a processed pair is dropped.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode  in  2  00 bypass, 01 N=4 (shift 2), 10 N=16 (shift 4), 11 N=64 (shift 6)
read_ready  in  1  CODEC has an L/R pair available
write_ready  in  1  CODEC can accept an L/R pair
readdata_left  in  24  CODEC left sample, two's complement
readdata_right  in  24  CODEC right sample, two's complement
read  out  1  one-cycle pop strobe to the CODEC
write  out  1  one-cycle push strobe to the CODEC
writedata_left  out  24  filtered left sample, registered
writedata_right  out  24  filtered right sample, registered
busy  out  1  high in any state other than IDLE
drop_cnt  out  16  count of pairs dropped on write timeout, saturating

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset values: state IDLE; read=0, write=0, writedata_*=0, busy=0, drop_cnt=0; accumulators=0, fill=0, wr_ptr=0, active_mode=00. Delay-line RAM is not cleared.
- FSM sequence: IDLE -> CAPT -> RD_L -> UPD_L -> RD_R -> UPD_R -> WAIT_WR -> WRITE -> IDLE.
- IDLE: when read_ready=1, go to CAPT and sample mode.
  - If mode differs from active_mode: active_mode<=mode, both accumulators<=0, fill<=0.
- CAPT: read=1 for exactly this cycle; capture readdata_left/right into x_l/x_r on the same edge.
- RD_L: RAM read address = {L, wr_ptr - 2^k}, where k is the active shift. RAM read latency is 1 cycle.
- UPD_L:
  - s = x_l >>> k (arithmetic shift, sign preserved).
  - old = (fill >= 2^k) ? ram_q : 0.
  - acc_l <= acc_l + s - old.
  - Write s at {L, wr_ptr}.
  - writedata_left <= new acc_l.
- RD_R / UPD_R: identical steps on the right channel. At the end of UPD_R: wr_ptr <= wr_ptr + 1 (wraps modulo 2^MAX_SHIFT); fill <= min(fill + 1, 2^MAX_SHIFT).
- Bypass (active_mode=00): UPD states load writedata_* = x_* directly; accumulators, fill and RAM are untouched.
- Arithmetic: all datapath values are 24-bit signed. The sum of 2^k samples each shifted by k cannot overflow, so no saturation logic.
- WAIT_WR:
  - write_ready=1 -> WRITE.
  - Otherwise count; at WR_TIMEOUT cycles go to IDLE with the pair discarded and drop_cnt+1 (saturating at 16'hFFFF). Filter state is kept.
- WRITE: write=1 for exactly this cycle -> IDLE.
- Latency: write strobe is at least 6 cycles after the read strobe. read and write are never high in the same cycle. At most one pair is in flight.
- read_ready is ignored outside IDLE.
- mode changes are ignored outside IDLE.
- reset asserted mid-sequence: return to IDLE next edge with reset values; no strobe is issued on that edge.

Optional Feature:
DITHER_EN
- Defined: a 3-bit counter c increments once per completed WRITE. Before shifting, x_* is replaced by x_* + {{10{c[2]}}, c, 11'd0} (signed add, wraps at 24 bits). Applies in bypass too.
- Undefined: no dither; x_* is used unmodified and the counter is not built.

Test Plan:
- Reset then idle, read_ready=0 -> read=write=busy=0, writedata_*=0, drop_cnt=0; no strobes for 100 cycles.
- mode=00, feed L=24'h123456, R=24'hFEDCBA, write_ready=1 -> one read strobe, write strobe 6 cycles later, outputs equal inputs.
- mode=01, 6 pairs L=24'h000400, R=24'hFFFFF0 -> L outputs 100,200,300,400,400,400 (hex); R outputs FFFFFC,FFFFF8,FFFFF4,FFFFF0,FFFFF0,FFFFF0.
- mode=10 steady at L=24'h001000 for 20 pairs, then switch to mode=01 -> first output after the switch is 24'h000400 (history flushed), ramping to 24'h001000 by the fourth pair.
- write_ready held 0 for more than WR_TIMEOUT cycles -> no write strobe, drop_cnt=1, FSM returns to IDLE and accepts the next pair normally.
- Reset pulsed during UPD_L -> next cycle IDLE, no write strobe, accumulators 0; the next pair behaves as the first pair after reset.

Source files
------------

// File: rtl/audio_filter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : audio_filter_sched
//  Purpose  : Sequencer between the audio CODEC FIFO interface and one shared
//             moving-average datapath. For each stereo sample it pops one L/R
//             pair, time-multiplexes a single adder/subtractor and a single
//             delay-line RAM between the left and right channels, then pushes
//             the filtered pair back to the CODEC. The window length is
//             selected at run time on sample boundaries. A change of length
//             flushes the filter history.
//  Ports    : clk, reset (synchronous, active-high)
//             mode[1:0]        00 bypass, 01 N=4, 10 N=16, 11 N=64
//             read_ready       CODEC has an L/R pair available
//             write_ready      CODEC can accept an L/R pair
//             readdata_left/right[23:0]   input samples, two's complement
//             read / write     one-cycle pop / push strobes
//             writedata_left/right[23:0]  filtered samples, registered
//             busy             FSM is not in IDLE
//             drop_cnt[15:0]   pairs dropped on write timeout, saturating
//  Options  : `define DITHER_EN adds a 3-bit dither counter. The counter steps
//             once per completed write. Its value is added to each sample
//             before the shift.
//  Revision : 1.0  initial release
// ============================================================================
module audio_filter_sched #(
    parameter int MAX_SHIFT  = 6,
    parameter int WR_TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic [23:0] readdata_left,
    input  logic [23:0] readdata_right,
    output logic        read,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    localparam int               c_DEPTH = 1 << MAX_SHIFT;
    localparam int               c_TW    = $clog2(WR_TIMEOUT + 1);
    localparam logic [MAX_SHIFT:0] c_FULL = (MAX_SHIFT + 1)'(c_DEPTH);
    localparam logic [c_TW-1:0]  c_TO_LAST = c_TW'(WR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPT    = 3'd1,
        S_RD_L    = 3'd2,
        S_UPD_L   = 3'd3,
        S_RD_R    = 3'd4,
        S_UPD_R   = 3'd5,
        S_WAIT_WR = 3'd6,
        S_WRITE   = 3'd7
    } state_t;

    state_t r_state;
    state_t w_next;

    // Delay line: left channel in the lower half, right channel in the upper half.
    logic [23:0]           r_mem [0:2*c_DEPTH-1];
    logic [23:0]           r_ram_q;

    logic signed [23:0]    r_x_l, r_x_r;
    logic signed [23:0]    r_acc_l, r_acc_r;
    logic [MAX_SHIFT:0]    r_fill;
    logic [MAX_SHIFT-1:0]  r_wr_ptr;
    logic [1:0]            r_active_mode;
    logic [c_TW-1:0]       r_wait_cnt;

    logic                  w_ch;        // 0 = left slot, 1 = right slot
    logic                  w_filt;      // filtering (not bypass)
    logic [2:0]            w_k;
    logic [MAX_SHIFT:0]    w_win;
    logic [MAX_SHIFT-1:0]  w_rd_ptr;
    logic signed [23:0]    w_dith;
    logic signed [23:0]    w_x_eff;
    logic signed [23:0]    w_s;
    logic signed [23:0]    w_old;
    logic signed [23:0]    w_acc_new;

`ifdef DITHER_EN
    logic [2:0] r_dith;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dith <= 3'd0;
        end else if (r_state == S_WRITE) begin
            r_dith <= r_dith + 3'd1;
        end
    end

    assign w_dith = {{10{r_dith[2]}}, r_dith, 11'd0};
`else
    assign w_dith = '0;
`endif

    // ------------------------------------------------------------------
    // Shared datapath: one channel is served per RD/UPD state pair.
    // ------------------------------------------------------------------
    always_comb begin
        w_k = 3'd0;
        case (r_active_mode)
            2'b01:   w_k = 3'd2;
            2'b10:   w_k = 3'd4;
            2'b11:   w_k = 3'd6;
            default: w_k = 3'd0;
        endcase
    end

    assign w_filt    = (r_active_mode != 2'b00);
    assign w_ch      = (r_state == S_RD_R) || (r_state == S_UPD_R);
    assign w_win     = c_FULL'(1) << w_k;
    // Oldest sample in the window sits 2^k entries behind the write pointer.
    // For the largest window this is the slot about to be overwritten, which
    // works because the read happens one cycle before the write.
    assign w_rd_ptr  = r_wr_ptr - w_win[MAX_SHIFT-1:0];
    assign w_x_eff   = (w_ch ? r_x_r : r_x_l) + w_dith;
    assign w_s       = w_x_eff >>> w_k;
    // Until the window has filled, the RAM holds stale history from an
    // earlier mode or a power-up. Treat that history as zero.
    assign w_old     = (r_fill >= w_win) ? r_ram_q : 24'sd0;
    assign w_acc_new = (w_ch ? r_acc_r : r_acc_l) + w_s - w_old;

    // Delay-line RAM: one-cycle read latency. It is not reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_RD_L) || (r_state == S_RD_R)) begin
            r_ram_q <= r_mem[{w_ch, w_rd_ptr}];
        end
        if (!reset && w_filt && ((r_state == S_UPD_L) || (r_state == S_UPD_R))) begin
            r_mem[{w_ch, r_wr_ptr}] <= w_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register and next-state / strobe decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        read   = 1'b0;
        write  = 1'b0;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    if (read_ready) w_next = S_CAPT;
            S_CAPT:    begin
                           read   = !reset;  // no strobe on a reset edge
                           w_next = S_RD_L;
                       end
            S_RD_L:    w_next = S_UPD_L;
            S_UPD_L:   w_next = S_RD_R;
            S_RD_R:    w_next = S_UPD_R;
            S_UPD_R:   w_next = S_WAIT_WR;
            S_WAIT_WR: begin
                           if (write_ready)
                               w_next = S_WRITE;
                           else if (r_wait_cnt == c_TO_LAST)
                               w_next = S_IDLE;
                       end
            S_WRITE:   begin
                           write  = !reset;
                           w_next = S_IDLE;
                       end
            default:   w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_l           <= '0;
            r_x_r           <= '0;
            r_acc_l         <= '0;
            r_acc_r         <= '0;
            r_fill          <= '0;
            r_wr_ptr        <= '0;
            r_active_mode   <= 2'b00;
            r_wait_cnt      <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            drop_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Mode is only taken at a sample boundary. A new window
                    // length restarts the average from empty.
                    if (read_ready && (mode != r_active_mode)) begin
                        r_active_mode <= mode;
                        r_acc_l       <= '0;
                        r_acc_r       <= '0;
                        r_fill        <= '0;
                    end
                end
                S_CAPT: begin
                    r_x_l <= readdata_left;
                    r_x_r <= readdata_right;
                end
                S_UPD_L: begin
                    if (w_filt) begin
                        r_acc_l        <= w_acc_new;
                        writedata_left <= w_acc_new;
                    end else begin
                        writedata_left <= w_x_eff;
                    end
                end
                S_UPD_R: begin
                    if (w_filt) begin
                        r_acc_r         <= w_acc_new;
                        writedata_right <= w_acc_new;
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                        if (r_fill != c_FULL)
                            r_fill <= r_fill + 1'b1;
                    end else begin
                        writedata_right <= w_x_eff;
                    end
                    r_wait_cnt <= '0;
                end
                S_WAIT_WR: begin
                    if (!write_ready) begin
                        if (r_wait_cnt == c_TO_LAST) begin
                            r_wait_cnt <= '0;
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_filter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_filter_sched
//  Purpose  : Directed self-checking bench for audio_filter_sched. Covers
//             reset, bypass, N=4 ramp, mode switch with flush, write timeout
//             and reset in mid-sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_audio_filter_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        read_ready;
    logic        write_ready;
    logic [23:0] readdata_left;
    logic [23:0] readdata_right;
    logic        read;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        busy;
    logic [15:0] drop_cnt;

    int tests  = 0;
    int failed = 0;

    audio_filter_sched #(.MAX_SHIFT(6), .WR_TIMEOUT(2048)) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .read_ready      (read_ready),
        .write_ready     (write_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    // Presents one pair and waits for the read strobe and then the write
    // strobe. Both waits are bounded. Sampling is done on negedges.
    task automatic run_pair(input logic [1:0] m, input logic [23:0] l, input logic [23:0] r,
                            input logic wr, input int budget,
                            output logic got_read, output logic got_write, output int lat,
                            output logic [23:0] out_l, output logic [23:0] out_r);
        got_read  = 1'b0;
        got_write = 1'b0;
        lat       = 0;
        out_l     = '0;
        out_r     = '0;
        @(negedge clk);
        mode           = m;
        readdata_left  = l;
        readdata_right = r;
        write_ready    = wr;
        read_ready     = 1'b1;
        for (int i = 0; i < 20 && !got_read; i++) begin
            @(negedge clk);
            if (read) got_read = 1'b1;
        end
        read_ready = 1'b0;
        if (got_read) begin
            for (int i = 0; i < budget && !got_write; i++) begin
                @(negedge clk);
                lat++;
                if (write) begin
                    got_write = 1'b1;
                    out_l     = writedata_left;
                    out_r     = writedata_right;
                end
            end
        end
    endtask

    task automatic test_reset();
        int strobes = 0;
        reset = 1'b1;
        mode = 2'b00; read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({read, write, busy} !== 3'b000 || writedata_left !== 24'h0 ||
            writedata_right !== 24'h0 || drop_cnt !== 16'h0) begin
            failed++;
            $display("FAIL reset_values: rd=%b wr=%b busy=%b wl=%h wr=%h drop=%h, want all 0",
                     read, write, busy, writedata_left, writedata_right, drop_cnt);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (read || write || busy) strobes++;
        end
        tests++;
        if (strobes !== 0) begin
            failed++;
            $display("FAIL idle_quiet: %0d active cycles, want 0", strobes);
        end
    endtask

    task automatic test_bypass();
        logic gr, gw; int lat; logic [23:0] ol, orr;
        run_pair(2'b00, 24'h123456, 24'hFEDCBA, 1'b1, 50, gr, gw, lat, ol, orr);
        tests++;
        if (!gr || !gw || lat !== 6) begin
            failed++;
            $display("FAIL bypass_latency: read=%b write=%b lat=%0d, want 1 1 6", gr, gw, lat);
        end
        tests++;
        if (ol !== 24'h123456 || orr !== 24'hFEDCBA) begin
            failed++;
            $display("FAIL bypass_data: L=%h R=%h, want 123456 FEDCBA", ol, orr);
        end
    endtask

    task automatic test_n4_ramp();
        logic [23:0] exp_l [6];
        logic [23:0] exp_r [6];
        logic gr, gw; int lat; logic [23:0] ol, orr;
        exp_l = '{24'h000100, 24'h000200, 24'h000300, 24'h000400, 24'h000400, 24'h000400};
        exp_r = '{24'hFFFFFC, 24'hFFFFF8, 24'hFFFFF4, 24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0};
        for (int i = 0; i < 6; i++) begin
            run_pair(2'b01, 24'h000400, 24'hFFFFF0, 1'b1, 50, gr, gw, lat, ol, orr);
            tests++;
            if (!gw || ol !== exp_l[i] || orr !== exp_r[i]) begin
                failed++;
                $display("FAIL n4_pair%0d: wrote=%b L=%h R=%h, want L=%h R=%h",
                         i, gw, ol, orr, exp_l[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [23:0] exp_l [4];
        logic gr, gw; int lat; logic [23:0] ol, orr;
        logic [23:0] first_l, last_l;
        first_l = '0; last_l = '0;
        for (int i = 0; i < 20; i++) begin
            run_pair(2'b10, 24'h001000, 24'h000000, 1'b1, 50, gr, gw, lat, ol, orr);
            if (i == 0) first_l = ol;
            last_l = ol;
        end
        tests++;
        if (first_l !== 24'h000100 || last_l !== 24'h001000) begin
            failed++;
            $display("FAIL n16_ramp: first=%h last=%h, want 000100 001000", first_l, last_l);
        end
        exp_l = '{24'h000400, 24'h000800, 24'h000C00, 24'h001000};
        for (int i = 0; i < 4; i++) begin
            run_pair(2'b01, 24'h001000, 24'h000000, 1'b1, 50, gr, gw, lat, ol, orr);
            tests++;
            if (!gw || ol !== exp_l[i] || orr !== 24'h0) begin
                failed++;
                $display("FAIL switch_pair%0d: L=%h R=%h, want L=%h R=000000", i, ol, orr, exp_l[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic gr, gw; int lat; logic [23:0] ol, orr;
        run_pair(2'b01, 24'h001000, 24'h000000, 1'b0, 2100, gr, gw, lat, ol, orr);
        tests++;
        if (!gr || gw) begin
            failed++;
            $display("FAIL timeout_no_write: read=%b write=%b, want 1 0", gr, gw);
        end
        tests++;
        if (drop_cnt !== 16'd1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL timeout_drop: drop_cnt=%0d busy=%b, want 1 0", drop_cnt, busy);
        end
        // The dropped pair was still filtered, so the running average remains at 0x1000.
        run_pair(2'b01, 24'h001000, 24'h000000, 1'b1, 50, gr, gw, lat, ol, orr);
        tests++;
        if (!gw || lat !== 6 || ol !== 24'h001000) begin
            failed++;
            $display("FAIL timeout_recover: write=%b lat=%0d L=%h, want 1 6 001000", gw, lat, ol);
        end
    endtask

    task automatic test_reset_mid();
        logic gr, gw; int lat; logic [23:0] ol, orr;
        int wr_seen = 0;
        gr = 1'b0;
        @(negedge clk);
        mode = 2'b01; readdata_left = 24'h000400; readdata_right = 24'hFFFFF0;
        write_ready = 1'b1; read_ready = 1'b1;
        for (int i = 0; i < 20 && !gr; i++) begin
            @(negedge clk);
            if (read) gr = 1'b1;
        end
        read_ready = 1'b0;
        @(negedge clk);           // RD_L
        @(negedge clk);           // UPD_L
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (!gr || busy !== 1'b0 || write !== 1'b0 || writedata_left !== 24'h0) begin
            failed++;
            $display("FAIL reset_mid_state: read_seen=%b busy=%b write=%b L=%h, want 1 0 0 000000",
                     gr, busy, write, writedata_left);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (write) wr_seen++;
        end
        tests++;
        if (wr_seen !== 0) begin
            failed++;
            $display("FAIL reset_mid_no_write: %0d write strobes, want 0", wr_seen);
        end
        run_pair(2'b01, 24'h000400, 24'hFFFFF0, 1'b1, 50, gr, gw, lat, ol, orr);
        tests++;
        if (!gw || ol !== 24'h000100 || orr !== 24'hFFFFFC || drop_cnt !== 16'd0) begin
            failed++;
            $display("FAIL reset_mid_first_pair: L=%h R=%h drop=%0d, want 000100 FFFFFC 0",
                     ol, orr, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_n4_ramp();
        test_mode_switch();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
